// File: rtl/srl2par_ctrl.sv
// Serial-to-parallel framing controller: hunts a 4-bit sync, collects W=4*NIBBLES bits LSB-first (parity via SRL2PAR_CTRL_PARITY_EN).
// Latency: par_valid rises 1 cycle after the last data bit (or after the parity bit when parity is enabled).
// Backpressure: one-entry output slot; a word completing while the slot is full is dropped and sets sticky ovf.
module srl2par_ctrl #(
    parameter int         NIBBLES = 2,
    parameter logic [3:0] SYNC    = 4'b1101
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 en,
    input  logic                 srl,
    input  logic                 srl_vld,
    output logic [4*NIBBLES-1:0] par,
    output logic                 par_valid,
    input  logic                 par_ready,
    output logic                 busy,
    output logic                 ovf,
    output logic                 par_err,
    input  logic                 flag_clr
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HUNT    = 2'd1,
`ifdef SRL2PAR_CTRL_PARITY_EN
        ST_COLLECT = 2'd2,
        ST_PARITY  = 2'd3
`else
        ST_COLLECT = 2'd2
`endif
    } state_t;

    state_t          r_state;
    logic [3:0]      r_hunt_sr;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_shift;
    logic [W-1:0]    r_par;
    logic            r_par_valid;
    logic            r_ovf;
    logic            r_busy;

    logic [3:0]      w_hunt_nxt;
    logic [W-1:0]    w_shift_nxt;
    logic [W-1:0]    w_word;
    logic            w_last_bit;
    logic            w_slot_free;
    logic            w_deliver;

    assign w_hunt_nxt  = {srl, r_hunt_sr[3:1]};
    assign w_last_bit  = (r_cnt == CW'(W - 1));
    // A word may load on the same edge the current one is consumed.
    assign w_slot_free = !r_par_valid || par_ready;

    always_comb begin
        w_shift_nxt        = r_shift;
        w_shift_nxt[r_cnt] = srl;
    end

`ifdef SRL2PAR_CTRL_PARITY_EN
    logic r_par_err;
    logic w_par_ok;
    logic w_par_bad;

    assign w_par_ok  = (srl == ^r_shift);
    assign w_word    = r_shift;
    assign w_deliver = en && srl_vld && (r_state == ST_PARITY) && w_par_ok;
    assign w_par_bad = en && srl_vld && (r_state == ST_PARITY) && !w_par_ok;
    assign par_err   = r_par_err;
`else
    assign w_word    = w_shift_nxt;
    assign w_deliver = en && srl_vld && (r_state == ST_COLLECT) && w_last_bit;
    assign par_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_) begin
            r_state     <= ST_IDLE;
            r_hunt_sr   <= 4'd0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_par       <= '0;
            r_par_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SRL2PAR_CTRL_PARITY_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            if (r_par_valid && par_ready) begin
                r_par_valid <= 1'b0;
            end
            // Clears come first so a same-cycle set takes priority.
            if (flag_clr) begin
                r_ovf     <= 1'b0;
`ifdef SRL2PAR_CTRL_PARITY_EN
                r_par_err <= 1'b0;
`endif
            end
            if (w_deliver) begin
                if (w_slot_free) begin
                    r_par       <= w_word;
                    r_par_valid <= 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end
`ifdef SRL2PAR_CTRL_PARITY_EN
            if (w_par_bad) begin
                r_par_err <= 1'b1;
            end
`endif

            if (!en) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state   <= ST_HUNT;
                        r_busy    <= 1'b1;
                        r_hunt_sr <= 4'd0;
                    end
                    ST_HUNT: begin
                        if (srl_vld) begin
                            r_hunt_sr <= w_hunt_nxt;
                            if (w_hunt_nxt == SYNC) begin
                                r_state <= ST_COLLECT;
                                r_cnt   <= '0;
                            end
                        end
                    end
                    ST_COLLECT: begin
                        if (srl_vld) begin
                            r_shift <= w_shift_nxt;
                            r_cnt   <= r_cnt + CW'(1);
                            if (w_last_bit) begin
`ifdef SRL2PAR_CTRL_PARITY_EN
                                r_state   <= ST_PARITY;
`else
                                r_state   <= ST_HUNT;
                                r_hunt_sr <= 4'd0;
`endif
                            end
                        end
                    end
`ifdef SRL2PAR_CTRL_PARITY_EN
                    ST_PARITY: begin
                        if (srl_vld) begin
                            r_state   <= ST_HUNT;
                            r_hunt_sr <= 4'd0;
                        end
                    end
`endif
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign par       = r_par;
    assign par_valid = r_par_valid;
    assign ovf       = r_ovf;
    assign busy      = r_busy;

endmodule
